alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between two command requesters. Each requester presents an operation (operands, 3-bit select, carry-in) on a valid/ready channel. The block grants the ALU round-robin, drives the ALU inputs from registers, captures the 4-bit ALU result and returns it on the originating requester's response channel. It sits between the ALU and its clients (decode/execute and a secondary address/compare path) and is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operand/result widths, ALU select codes
// and the arbiter FSM state encoding.
package alu_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned ResW  = 4;
  localparam int unsigned SelW  = 3;

  typedef enum logic [SelW-1:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_PASSB = 3'b010,
    ALU_PASSA = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_NOTA  = 3'b110,
    ALU_XOR   = 3'b111
  } alu_sel_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The requester not granted last wins a tie;
// last_grant resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant_q;

  always_comb begin
    gnt0 = en & req0 & (~req1 | last_grant_q);
    gnt1 = en & req1 & (~req0 | ~last_grant_q);
  end

  // A grant is also the handshake, since ready is the grant itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_grant_q <= gnt1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU between two requesters: round-robin accept,
// registered ALU inputs, one-cycle execute, result returned to the owner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [DataW-1:0] req0_a,
  input  logic [DataW-1:0] req1_a,
  input  logic [DataW-1:0] req0_b,
  input  logic [DataW-1:0] req1_b,
  input  logic [SelW-1:0]  req0_s,
  input  logic [SelW-1:0]  req1_s,
  input  logic             req0_cin,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [ResW-1:0]  rsp_f,
  output logic [DataW-1:0] alu_a,
  output logic [DataW-1:0] alu_b,
  output logic [SelW-1:0]  alu_s,
  output logic             alu_cin,
  input  logic [ResW-1:0]  alu_f,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  arb_state_e state_q;
  logic       owner_q;
  logic       accept_en;
  logic       gnt0;
  logic       gnt1;
  logic       owner_rsp_ready;

  assign accept_en       = (state_q == StIdle) & ~rst;
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
  assign req0_ready      = gnt0;
  assign req1_ready      = gnt1;

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept_en),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_f      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      alu_cin    <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt0 | gnt1) begin
            alu_a   <= gnt1 ? req1_a : req0_a;
            alu_b   <= gnt1 ? req1_b : req0_b;
            alu_s   <= gnt1 ? req1_s : req0_s;
            alu_cin <= gnt1 ? req1_cin : req0_cin;
            owner_q <= gnt1;
            busy    <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_f      <= alu_f;
          rsp0_valid <= ~owner_q;
          rsp1_valid <= owner_q;
          state_q    <= StResp;
        end
        StResp: begin
          // The non-owner's rsp_ready is deliberately ignored.
          if (owner_rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state_q    <= StIdle;
            if (op_count != '1) begin
              op_count <= op_count + CNT_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: a behavioural ALU drives alu_f, and a
// negedge monitor checks grants, timing, routing, results and the saturating counter.
module tb_alu_arbiter;

  localparam int unsigned CntW   = 2;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  typedef struct {
    int         own;
    logic [3:0] f;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      v;
  logic [1:0]      rdy;
  logic [31:0]     pa [2];
  logic [31:0]     pb [2];
  logic [2:0]      ps [2];
  logic [1:0]      pc;
  logic [1:0]      rsp_v;
  logic [1:0]      rsp_r;
  logic [3:0]      rsp_f;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [2:0]      alu_s;
  logic            alu_cin;
  logic [3:0]      alu_f;
  logic            busy;
  logic [CntW-1:0] op_count;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   phase = 0;
  int   last = 1;
  int   cnt = 0;
  bit   pend_inc = 0;
  bit   rst_prev = 0;
  logic [31:0] lo_a = 0;
  logic [31:0] lo_b = 0;
  logic [2:0]  lo_s = 0;
  logic        lo_c = 0;
  logic [1:0]  hold = 0;
  bit          rnd_mode = 0;

  always #5 clk = ~clk;

  // Reference ALU: full 32-bit result, low 4 bits returned.
  function automatic logic [3:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] s, input logic cin);
    logic [31:0] r;
    case (s)
      3'd0:    r = a + b + {31'd0, cin};
      3'd1:    r = a + ~b + {31'd0, cin};
      3'd2:    r = b;
      3'd3:    r = a;
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = ~a;
      default: r = a ^ b;
    endcase
    return r[3:0];
  endfunction

  assign alu_f = alu_ref(alu_a, alu_b, alu_s, alu_cin);

  alu_arbiter #(.CNT_W(CntW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req1_valid (v[1]),
    .req0_ready (rdy[0]),
    .req1_ready (rdy[1]),
    .req0_a     (pa[0]),
    .req1_a     (pa[1]),
    .req0_b     (pb[0]),
    .req1_b     (pb[1]),
    .req0_s     (ps[0]),
    .req1_s     (ps[1]),
    .req0_cin   (pc[0]),
    .req1_cin   (pc[1]),
    .rsp0_valid (rsp_v[0]),
    .rsp1_valid (rsp_v[1]),
    .rsp0_ready (rsp_r[0]),
    .rsp1_ready (rsp_r[1]),
    .rsp_f      (rsp_f),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_cin    (alu_cin),
    .alu_f      (alu_f),
    .busy       (busy),
    .op_count   (op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp_valid", {30'd0, rsp_v}, 0);
    chk("rst_rsp_f", {28'd0, rsp_f}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_s", {29'd0, alu_s}, 0);
    chk("rst_alu_cin", {31'd0, alu_cin}, 0);
    chk("rst_op_count", 32'(op_count), 0);
  endtask

  task automatic chk_alu_hold(input string name);
    chk({name, "_a"}, alu_a, lo_a);
    chk({name, "_b"}, alu_b, lo_b);
    chk({name, "_s"}, {29'd0, alu_s}, {29'd0, lo_s});
    chk({name, "_cin"}, {31'd0, alu_cin}, {31'd0, lo_c});
  endtask

  // Monitor and scoreboard: all DUT outputs sampled on the falling edge.
  initial begin
    int g;
    int own;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready_in_rst", {30'd0, rdy}, 0);
        if (rst_prev) check_reset();
        q.delete();
        phase = 0; last = 1; cnt = 0; pend_inc = 0; rst_prev = 1;
        lo_a = 0; lo_b = 0; lo_s = 0; lo_c = 0;
      end else begin
        if (rst_prev) check_reset();
        rst_prev = 0;
        if (pend_inc) begin
          cnt = (cnt == CntMax) ? cnt : cnt + 1;
          pend_inc = 0;
        end
        chk("op_count", 32'(op_count), cnt);
        case (phase)
          0: begin
            chk("busy_idle", {31'd0, busy}, 0);
            chk("rsp_valid_idle", {30'd0, rsp_v}, 0);
            chk_alu_hold("alu_hold");
            if (v[0] && (!v[1] || last == 1)) g = 0;
            else if (v[1]) g = 1;
            else g = -1;
            chk("grant", {30'd0, rdy}, (g == 0) ? 1 : (g == 1) ? 2 : 0);
            if (g >= 0) begin
              q.push_back('{own: g, f: alu_ref(pa[g], pb[g], ps[g], pc[g])});
              lo_a = pa[g]; lo_b = pb[g]; lo_s = ps[g]; lo_c = pc[g];
              last = g;
              phase = 1;
            end
          end
          1: begin
            chk("busy_exec", {31'd0, busy}, 1);
            chk("ready_exec", {30'd0, rdy}, 0);
            chk("rsp_valid_exec", {30'd0, rsp_v}, 0);
            chk_alu_hold("alu_exec");
            phase = 2;
          end
          default: begin
            chk("busy_resp", {31'd0, busy}, 1);
            chk("ready_resp", {30'd0, rdy}, 0);
            chk("scoreboard_depth", q.size(), 1);
            if (q.size() > 0) begin
              own = q[0].own;
              chk("rsp_route", {30'd0, rsp_v}, (own == 1) ? 2 : 1);
              chk("rsp_f", {28'd0, rsp_f}, {28'd0, q[0].f});
              if (rsp_r[own]) begin
                void'(q.pop_front());
                pend_inc = 1;
                phase = 0;
              end
            end
          end
        endcase
      end
    end
  end

  // Response-side requesters: always ready, random, or held low on demand.
  initial begin
    rsp_r = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (hold[n]) rsp_r[n] = 1'b0;
        else if (rnd_mode) rsp_r[n] = ($urandom_range(0, 2) != 0);
        else rsp_r[n] = 1'b1;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] s, input logic cin);
    bit ok;
    ok = 0;
    v[n] = 1'b1; pa[n] = a; pb[n] = b; ps[n] = s; pc[n] = cin;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rdy[n]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: requester %0d got no ready, want ready within 300 cycles",
               n);
    end
    @(posedge clk);
    #1;
    v[n] = 1'b0;
  endtask

  task automatic send_rand(input int n);
    send(n, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (phase == 0 && q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("drain", {31'd0, done}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v = 2'b00;
    pc = 2'b00;
    for (int n = 0; n < 2; n++) begin
      pa[n] = 0; pb[n] = 0; ps[n] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed single ops: add, subtract with carry, truncated add.
    send(0, 32'd3, 32'd4, 3'd0, 1'b0);
    send(1, 32'd5, 32'd3, 3'd1, 1'b1);
    send(0, 32'h1F, 32'd1, 3'd0, 1'b0);
    wait_idle();

    // Continuous contention with distinct ops.
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 32'(100 + i), 32'(7 * i), 3'(i), 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 32'(200 + 3 * i), 32'd5, 3'(i + 4), 1'b1);
      end
    join
    wait_idle();

    // Backpressure: owner holds rsp_ready low while the other requester waits.
    hold[0] = 1'b1;
    fork
      send(0, 32'h1234_5678, 32'h0F0F_0F0F, 3'd4, 1'b0);
      begin
        @(posedge clk);
        #1;
        send(1, 32'hA, 32'h6, 3'd7, 1'b0);
      end
      begin
        repeat (7) begin
          @(posedge clk);
          #1;
        end
        hold[0] = 1'b0;
      end
    join
    wait_idle();

    // Reset while the op is in EXEC; then req0 must win the first contention.
    send(0, 32'd9, 32'd9, 3'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      send(0, 32'hFFFF_FFFE, 32'd1, 3'd0, 1'b1);
      send(1, 32'hC, 32'h3, 3'd5, 1'b0);
    join
    wait_idle();

    // Randomized traffic with random gaps and random response backpressure.
    rnd_mode = 1'b1;
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
        send_rand(0);
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
        send_rand(1);
      end
    join
    wait_idle();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
